// File: rtl/cmult_pipe_if.sv
`timescale 1ns/1ps
// cmult_pipe_if: operand/result bundle for cmult_pipe.
// master: sample source (drives en, in_valid, a_*, b_*; receives out_valid, o_*, ovf).
// slave : the multiplier. conj exists only in builds with CMULT_CONJ_EN defined.
interface cmult_pipe_if #(
  parameter int WA = 16,
  parameter int WB = 16,
  parameter int WO = 16
);
  logic                 en;
  logic                 in_valid;
  logic signed [WA-1:0] a_re;
  logic signed [WA-1:0] a_im;
  logic signed [WB-1:0] b_re;
  logic signed [WB-1:0] b_im;
`ifdef CMULT_CONJ_EN
  logic                 conj;
`endif
  logic                 out_valid;
  logic signed [WO-1:0] o_re;
  logic signed [WO-1:0] o_im;
  logic                 ovf;

  modport master (
`ifdef CMULT_CONJ_EN
    output conj,
`endif
    output en, in_valid, a_re, a_im, b_re, b_im,
    input  out_valid, o_re, o_im, ovf
  );

  modport slave (
`ifdef CMULT_CONJ_EN
    input  conj,
`endif
    input  en, in_valid, a_re, a_im, b_re, b_im,
    output out_valid, o_re, o_im, ovf
  );
endinterface

// File: rtl/cmult_pipe.sv
`timescale 1ns/1ps
// cmult_pipe: pipelined signed complex multiply o = a*b (a*conj(b) per sample when
//   built with CMULT_CONJ_EN), scaled by >>>SHIFT with optional round-half-up, saturated to WO.
// Latency 3+EXTRA_PIPE enabled clocks; no backpressure, en=0 freezes every stage.
// Ports: clk, reset_b (async active-low), io (cmult_pipe_if.slave: en, in_valid, a/b in; out_valid, o, ovf out).
module cmult_pipe #(
  parameter int WA         = 16,
  parameter int WB         = 16,
  parameter int WO         = 16,
  parameter int SHIFT      = WA + WB - WO,
  parameter int ROUND      = 1,
  parameter int EXTRA_PIPE = 0
) (
  input  logic        clk,
  input  logic        reset_b,
  cmult_pipe_if.slave io
);
  localparam int WP = WA + WB;   // single product
  localparam int WS = WP + 1;    // sum/difference of two products, cannot overflow
  // Scaling width: one more bit than the sum so the rounding add never wraps,
  // and wide enough to hold the WO saturation limits.
  localparam int WC = ((WP + 2) > (WO + 1)) ? (WP + 2) : (WO + 1);

  localparam logic signed [WC-1:0] ONE  = WC'(1);
  localparam logic signed [WC-1:0] RND  = (ROUND != 0 && SHIFT > 0) ?
                                          (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [WC-1:0] MAXV = (ONE <<< (WO - 1)) - ONE;
  localparam logic signed [WC-1:0] MINV = -(ONE <<< (WO - 1));

  // Returns {saturated, value}.
  function automatic logic [WO:0] scale_sat(input logic signed [WS-1:0] p);
    logic signed [WC-1:0] r;
    r = (WC'(p) + RND) >>> SHIFT;
    if (r > MAXV)      scale_sat = {1'b1, MAXV[WO-1:0]};
    else if (r < MINV) scale_sat = {1'b1, MINV[WO-1:0]};
    else               scale_sat = {1'b0, r[WO-1:0]};
  endfunction

  logic                 v1, v2, v3;
  logic signed [WP-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [WS-1:0] p_re, p_im;
  logic signed [WS-1:0] s_re, s_im;
  logic signed [WO-1:0] r_re, r_im;
  logic signed [WO-1:0] q_re, q_im;
  logic                 sat_re, sat_im;
  logic                 ovf3;
  logic                 conj_sel;

`ifdef CMULT_CONJ_EN
  logic c1;
  assign conj_sel = c1;
`else
  assign conj_sel = 1'b0;
`endif

  // Stage 2 combinational: a*b or a*conj(b)
  always_comb begin
    s_re = WS'(m_rr) - WS'(m_ii);
    s_im = WS'(m_ri) + WS'(m_ir);
    if (conj_sel) begin
      s_re = WS'(m_rr) + WS'(m_ii);
      s_im = WS'(m_ir) - WS'(m_ri);
    end
  end

  // Stage 3 combinational: round, shift, saturate
  always_comb begin
    {sat_re, q_re} = scale_sat(p_re);
    {sat_im, q_im} = scale_sat(p_im);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      m_rr <= '0;
      m_ii <= '0;
      m_ri <= '0;
      m_ir <= '0;
      p_re <= '0;
      p_im <= '0;
      r_re <= '0;
      r_im <= '0;
      ovf3 <= 1'b0;
`ifdef CMULT_CONJ_EN
      c1   <= 1'b0;
`endif
    end else if (io.en) begin
      // Size casts sign-extend; the exact product always fits in WA+WB bits.
      v1   <= io.in_valid;
      m_rr <= WP'(io.a_re) * WP'(io.b_re);
      m_ii <= WP'(io.a_im) * WP'(io.b_im);
      m_ri <= WP'(io.a_re) * WP'(io.b_im);
      m_ir <= WP'(io.a_im) * WP'(io.b_re);
`ifdef CMULT_CONJ_EN
      c1   <= io.conj;
`endif
      v2   <= v1;
      p_re <= s_re;
      p_im <= s_im;
      v3   <= v2;
      r_re <= q_re;
      r_im <= q_im;
      ovf3 <= v2 & (sat_re | sat_im);  // flag only meaningful samples
    end
  end

  generate
    if (EXTRA_PIPE == 0) begin : g_nopipe
      assign io.out_valid = v3;
      assign io.o_re      = r_re;
      assign io.o_im      = r_im;
      assign io.ovf       = ovf3;
    end else begin : g_pipe
      logic                 xv   [EXTRA_PIPE];
      logic signed [WO-1:0] xre  [EXTRA_PIPE];
      logic signed [WO-1:0] xim  [EXTRA_PIPE];
      logic                 xovf [EXTRA_PIPE];

      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
          for (int i = 0; i < EXTRA_PIPE; i++) begin
            xv[i]   <= 1'b0;
            xre[i]  <= '0;
            xim[i]  <= '0;
            xovf[i] <= 1'b0;
          end
        end else if (io.en) begin
          xv[0]   <= v3;
          xre[0]  <= r_re;
          xim[0]  <= r_im;
          xovf[0] <= ovf3;
          for (int i = 1; i < EXTRA_PIPE; i++) begin
            xv[i]   <= xv[i-1];
            xre[i]  <= xre[i-1];
            xim[i]  <= xim[i-1];
            xovf[i] <= xovf[i-1];
          end
        end
      end

      assign io.out_valid = xv[EXTRA_PIPE-1];
      assign io.o_re      = xre[EXTRA_PIPE-1];
      assign io.o_im      = xim[EXTRA_PIPE-1];
      assign io.ovf       = xovf[EXTRA_PIPE-1];
    end
  endgenerate
endmodule

// File: tb/tb_cmult_pipe.sv
`timescale 1ns/1ps
// tb_cmult_pipe: directed checks of cmult_pipe in four builds:
//   dut0 SHIFT=15 ROUND=1, dut1 SHIFT=15 ROUND=0, dut3 SHIFT=0, dut2 SHIFT=15 EXTRA_PIPE=2 (random en).
// Ports: none; prints one summary line.
module tb_cmult_pipe;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  cmult_pipe_if #(.WA(16), .WB(16), .WO(16)) if0 ();
  cmult_pipe_if #(.WA(16), .WB(16), .WO(16)) if1 ();
  cmult_pipe_if #(.WA(16), .WB(16), .WO(16)) if2 ();
  cmult_pipe_if #(.WA(16), .WB(16), .WO(16)) if3 ();

  cmult_pipe #(.SHIFT(15), .ROUND(1)) dut0 (.clk(clk), .reset_b(reset_b), .io(if0));
  cmult_pipe #(.SHIFT(15), .ROUND(0)) dut1 (.clk(clk), .reset_b(reset_b), .io(if1));
  cmult_pipe #(.SHIFT(15), .EXTRA_PIPE(2)) dut2 (.clk(clk), .reset_b(reset_b), .io(if2));
  cmult_pipe #(.SHIFT(0)) dut3 (.clk(clk), .reset_b(reset_b), .io(if3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to dut0, dut1 and dut3.
  task automatic drive(input logic v, input int ar, input int ai, input int br, input int bi);
    if0.en = 1'b1; if1.en = 1'b1; if3.en = 1'b1;
    if0.in_valid = v; if1.in_valid = v; if3.in_valid = v;
    if0.a_re = 16'(ar); if1.a_re = 16'(ar); if3.a_re = 16'(ar);
    if0.a_im = 16'(ai); if1.a_im = 16'(ai); if3.a_im = 16'(ai);
    if0.b_re = 16'(br); if1.b_re = 16'(br); if3.b_re = 16'(br);
    if0.b_im = 16'(bi); if1.b_im = 16'(bi); if3.b_im = 16'(bi);
  endtask

`ifdef CMULT_CONJ_EN
  task automatic drive_conj(input logic cj);
    if0.conj = cj; if1.conj = cj; if3.conj = cj;
  endtask
`endif

  task automatic chk_zero(input string tag, input logic v, input logic signed [15:0] re,
                          input logic signed [15:0] im, input logic f);
    chk({tag, "_vld"}, v, 0);
    chk({tag, "_re"}, re, 0);
    chk({tag, "_im"}, im, 0);
    chk({tag, "_ovf"}, f, 0);
  endtask

  // Inputs, then expected {re, im, ovf} for round (r*), truncate (t*) and SHIFT=0 (z*).
  typedef struct {
    int ar, ai, br, bi;
    int rr, ri, ro;
    int tr, ti, to;
    int zr, zi, zo;
  } vec_t;
  localparam int NV = 11;
  vec_t tv [NV];

  typedef struct { int re; int im; int ovf; int tag; } exp_t;
  exp_t q [$];

  function automatic longint clamp16(input longint r);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  initial begin
    int en_cnt, sent, got;
    int ar, ai, br, bi, cj;
    longint pr, pi, rr, ri;
    exp_t e;

    tv[0]  = '{16384, 0, 16384, 0,           8192, 0, 0,      8192, 0, 0,      32767, 0, 1};
    tv[1]  = '{8192, 8192, 8192, -8192,      4096, 0, 0,      4096, 0, 0,      32767, 0, 1};
    // b_im=+32768 is not representable; +32767 is the nearest positive-saturation corner.
    tv[2]  = '{-32768, -32768, -32768, 32767, 32767, 1, 1,    32767, 1, 1,     32767, 32767, 1};
    tv[3]  = '{1, 0, 16384, 0,               1, 0, 0,         0, 0, 0,         16384, 0, 0};
    tv[4]  = '{-1, 0, 16384, 0,              0, 0, 0,         -1, 0, 0,        -16384, 0, 0};
    tv[5]  = '{-32768, -32768, 32767, -32767, -32768, 0, 1,   -32768, 0, 1,    -32768, 0, 1};
    tv[6]  = '{0, 1, 0, 1,                   0, 0, 0,         -1, 0, 0,        -1, 0, 0};
    tv[7]  = '{1000, 2000, 3000, -4000,      336, 61, 0,      335, 61, 0,      32767, 32767, 1};
    tv[8]  = '{-1000, 2000, 3000, 4000,      -336, 61, 0,     -336, 61, 0,     -32768, 32767, 1};
    // All four operands at -2^15: p_im = 2^31 must saturate, not wrap.
    tv[9]  = '{-32768, -32768, -32768, -32768, 0, 32767, 1,   0, 32767, 1,     0, 32767, 1};
    tv[10] = '{3, 4, 5, -6,                  0, 0, 0,         0, 0, 0,         39, 2, 0};

    drive(0, 0, 0, 0, 0);
`ifdef CMULT_CONJ_EN
    drive_conj(0);
    if2.conj = 1'b0;
`endif
    if2.en = 1'b1; if2.in_valid = 1'b0;
    if2.a_re = '0; if2.a_im = '0; if2.b_re = '0; if2.b_im = '0;

    // Reset state
    #12;
    chk_zero("rst0", if0.out_valid, if0.o_re, if0.o_im, if0.ovf);
    chk_zero("rst1", if1.out_valid, if1.o_re, if1.o_im, if1.ovf);
    chk_zero("rst2", if2.out_valid, if2.o_re, if2.o_im, if2.ovf);
    chk_zero("rst3", if3.out_valid, if3.o_re, if3.o_im, if3.ovf);
    @(negedge clk);
    reset_b = 1'b1;
    tick();

    // Single sample: out_valid high for exactly one cycle, 3 clocks later
    drive(1, 16384, 0, 16384, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("pulse_vld_c%0d", c), if0.out_valid, (c == 3) ? 1 : 0);
      if (c == 3) begin
        chk("pulse_re", if0.o_re, 8192);
        chk("pulse_im", if0.o_im, 0);
        chk("pulse_ovf", if0.ovf, 0);
      end
      tick();
    end

    // Saturating data without in_valid must not raise ovf
    drive(0, -32768, -32768, -32768, -32768);
    for (int c = 0; c < 4; c++) tick();
    chk("gated_ovf", if0.ovf, 0);
    chk("gated_vld", if0.out_valid, 0);

    // Table, streamed back-to-back
    for (int i = 0; i < NV + 3; i++) begin
      if (i >= 3) begin
        int j;
        j = i - 3;
        chk($sformatf("v%0d_rnd_vld", j), if0.out_valid, 1);
        chk($sformatf("v%0d_rnd_re", j), if0.o_re, tv[j].rr);
        chk($sformatf("v%0d_rnd_im", j), if0.o_im, tv[j].ri);
        chk($sformatf("v%0d_rnd_ovf", j), if0.ovf, tv[j].ro);
        chk($sformatf("v%0d_trn_re", j), if1.o_re, tv[j].tr);
        chk($sformatf("v%0d_trn_im", j), if1.o_im, tv[j].ti);
        chk($sformatf("v%0d_trn_ovf", j), if1.ovf, tv[j].to);
        chk($sformatf("v%0d_sh0_re", j), if3.o_re, tv[j].zr);
        chk($sformatf("v%0d_sh0_im", j), if3.o_im, tv[j].zi);
        chk($sformatf("v%0d_sh0_ovf", j), if3.ovf, tv[j].zo);
      end
      if (i < NV) drive(1, tv[i].ar, tv[i].ai, tv[i].br, tv[i].bi);
      else        drive(0, 0, 0, 0, 0);
      tick();
    end

`ifdef CMULT_CONJ_EN
    // Alternating conj per sample on the same operands
    for (int i = 0; i < 4 + 3; i++) begin
      if (i >= 3) begin
        int j;
        j = i - 3;
        chk($sformatf("conj%0d_re", j), if0.o_re, (j % 2 == 0) ? 0 : 4096);
        chk($sformatf("conj%0d_im", j), if0.o_im, (j % 2 == 0) ? 4096 : 0);
      end
      if (i < 4) begin
        drive(1, 8192, 8192, 8192, -8192);
        drive_conj((i % 2) == 0);
      end else begin
        drive(0, 0, 0, 0, 0);
        drive_conj(0);
      end
      tick();
    end
`endif

    // Streaming with random en through EXTRA_PIPE=2
    en_cnt = 0; sent = 0; got = 0; cj = 0;
    ar = int'($urandom_range(0, 65535)) - 32768; ai = int'($urandom_range(0, 65535)) - 32768;
    br = int'($urandom_range(0, 65535)) - 32768; bi = int'($urandom_range(0, 65535)) - 32768;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      if2.en = ($urandom_range(0, 2) != 0);
      if2.in_valid = (sent < 20);
      if2.a_re = 16'(ar); if2.a_im = 16'(ai); if2.b_re = 16'(br); if2.b_im = 16'(bi);
`ifdef CMULT_CONJ_EN
      cj = sent % 2;
      if2.conj = cj[0];
`endif
      tick();
      if (if2.en) begin
        en_cnt++;
        if (if2.in_valid) begin
          if (cj != 0) begin
            pr = longint'(ar) * br + longint'(ai) * bi;
            pi = longint'(ai) * br - longint'(ar) * bi;
          end else begin
            pr = longint'(ar) * br - longint'(ai) * bi;
            pi = longint'(ar) * bi + longint'(ai) * br;
          end
          rr = (pr + 64'sd16384) >>> 15;
          ri = (pi + 64'sd16384) >>> 15;
          e.re  = int'(clamp16(rr));
          e.im  = int'(clamp16(ri));
          e.ovf = (clamp16(rr) != rr || clamp16(ri) != ri) ? 1 : 0;
          e.tag = en_cnt;
          q.push_back(e);
          sent++;
          ar = int'($urandom_range(0, 65535)) - 32768; ai = int'($urandom_range(0, 65535)) - 32768;
          br = int'($urandom_range(0, 65535)) - 32768; bi = int'($urandom_range(0, 65535)) - 32768;
        end
        if (if2.out_valid) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stream_extra: output %0d with nothing outstanding", got);
          end else begin
            e = q.pop_front();
            chk($sformatf("s%0d_re", got), if2.o_re, e.re);
            chk($sformatf("s%0d_im", got), if2.o_im, e.im);
            chk($sformatf("s%0d_ovf", got), if2.ovf, e.ovf);
            chk($sformatf("s%0d_lat", got), en_cnt - e.tag + 1, 5);
          end
          got++;
        end
      end
    end
    chk("stream_count", got, 20);
    chk("stream_left", q.size(), 0);

    // Reset with samples in flight
    if2.en = 1'b1; if2.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1, 1000, 2000, 3000, -4000);
      tick();
    end
    chk("mid_pre_vld", if0.out_valid, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("mid_async_vld", if0.out_valid, 0);
    chk("mid_async_re", if0.o_re, 0);
    chk("mid_async_im", if0.o_im, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mid_post_vld%0d", c), if0.out_valid, 0);
      chk($sformatf("mid_post_ovf%0d", c), if0.ovf, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmult_pipe.md
Name: cmult_pipe

Overview:
- Parametrised pipelined signed complex multiplier for the DPD datapath: o = a*b, or a*conj(b) when the optional feature is built in.
- Next-generation replacement for the scalar truncating multiplier.
- Adds complex operands, a valid pipeline, clock enable, configurable output shift, rounding, saturation with overflow flag, and extra pipeline stages for timing closure.
- Sits between the basis-function generator and the coefficient accumulator.

Parameters:
- WA, 16, width of a_re/a_im (signed two's complement).
- WB, 16, width of b_re/b_im (signed two's complement).
- WO, 16, width of o_re/o_im (signed two's complement).
- SHIFT, WA+WB-WO, arithmetic right shift applied to the full-precision result; legal range 0..WA+WB.
- ROUND, 1, 1 = round half up (add 2^(SHIFT-1) before shifting), 0 = truncate (floor). Ignored when SHIFT=0.
- EXTRA_PIPE, 0, number of additional output register stages (0..8).

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- en  in  1  clock enable; low freezes the entire pipeline
- in_valid  in  1  input sample valid
- a_re  in  WA  operand a, real part
- a_im  in  WA  operand a, imaginary part
- b_re  in  WB  operand b, real part
- b_im  in  WB  operand b, imaginary part
- out_valid  out  1  output valid
- o_re  out  WO  result, real part
- o_im  out  WO  result, imaginary part
- ovf  out  1  saturation occurred on o_re or o_im of this sample

Behaviour:
- Reset: reset_b is asynchronous, active-low; clock is clk. All pipeline registers clear to 0, including out_valid, o_re, o_im and ovf. Release is synchronous to clk.
- Stage 1: register the four products ar*br, ai*bi, ar*bi, ai*br, each WA+WB bits signed. in_valid is registered alongside.
- Stage 2, sums at WA+WB+1 bits, no overflow possible:
  - p_re = ar*br - ai*bi
  - p_im = ar*bi + ai*br
- Stage 3, per component:
  - r = (p + (ROUND ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed wide enough that the rounding add cannot wrap.
  - If r > 2^(WO-1)-1, output 2^(WO-1)-1. If r < -2^(WO-1), output -2^(WO-1). Otherwise output r.
  - ovf = saturation on either component.
- Output stages: EXTRA_PIPE further registers delay o_re/o_im/ovf/out_valid identically.
- Latency: 3+EXTRA_PIPE enabled clocks from input to output.
- Enable handling:
  - All stages advance only when en=1.
  - While en=0, every register (data and valid) holds and outputs are stable.
  - No sample is lost or duplicated across any en pattern.
- Valid handling:
  - Data registers load every enabled cycle regardless of in_valid. Contents are don't-care when the associated valid is 0.
  - out_valid is a pure delayed copy of in_valid.
  - ovf is gated: asserted only when out_valid=1.
- Throughput: one sample per enabled clock, back-to-back, no bubbles.
- Reset mid-stream: in-flight samples are discarded and out_valid drops immediately (asynchronously).
- Boundary cases:
  - SHIFT=0: no rounding, saturation only.
  - SHIFT=WA+WB: result is the sign/round of p only.
  - The -2^(WA-1) * -2^(WB-1) corner must saturate correctly, not wrap.

Optional Feature:
- Macro: CMULT_CONJ_EN.
- When defined:
  - Extra input port conj  in  1, sampled with in_valid in stage 1 and carried down the pipe.
  - When conj=1, the sample computes a*conj(b): p_re = ar*br + ai*bi, p_im = ai*br - ar*bi.
  - Selection is per sample, with no extra latency.
- When undefined: the port is absent and the block always computes a*b.

Test Plan (WA=WB=WO=16, SHIFT=15, ROUND=1, EXTRA_PIPE=0 unless stated):
- Basic product: a=16384+j0, b=16384+j0, in_valid=1 for one clock -> 3 clocks later out_valid=1 for one cycle, o=8192+j0, ovf=0.
- Complex cross-terms: a=8192+j8192, b=8192-j8192 -> o_re=4096, o_im=0.
- Saturation: a=-32768-j32768, b=-32768+j32768 -> p_re=2^31, p_im=0, so o_re=32767, o_im=0, ovf=1.
- Rounding, ROUND=1: a=1+j0, b=16384+j0 -> o_re=1. Same with a=-1 -> o_re=0.
- Truncation, ROUND=0: the two rounding cases -> o_re=0 and o_re=-1 respectively.
- Streaming and enable: 20 back-to-back random samples with en toggled pseudo-randomly, EXTRA_PIPE=2 -> outputs match the bit-exact reference model in order, 5 enabled clocks latency, none dropped.
- Reset mid-stream: assert reset_b low with samples in flight -> out_valid=0 immediately, no stale outputs after release.
- CMULT_CONJ_EN build: a=8192+j8192, b=8192-j8192, conj=1 -> o_re=0, o_im=4096. Alternating conj per sample -> each result selected correctly.
